// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared states and dimensions for the systolic feeder
package systolic_pkg;

  localparam int N          = 4;
  localparam int STREAM_LEN = 7;
  localparam int DRAIN_LEN  = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/feeder_bank.sv
// rtl/feeder_bank.sv - 16-entry operand register file with diagonally skewed row or column reads
module feeder_bank
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit COL_READ   = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [3:0]              wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_en_i,
  input  logic [2:0]              rd_step_i,
  output logic [N*DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem [N*N];

  // element storage, cleared by reset, one write per cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < N*N; k++) mem[k] <= '0;
    end else if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // port p sees element (p, step-p) for rows or (step-p, p) for columns;
  // a negative difference wraps to a large unsigned value and reads as 0
  for (genvar p = 0; p < N; p++) begin : g_port
    logic [3:0] diff;
    logic [3:0] addr;
    assign diff = {1'b0, rd_step_i} - 4'(p);
    assign addr = COL_READ ? {diff[1:0], 2'(p)} : {2'(p), diff[1:0]};
    assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] =
      (rd_en_i && (diff < 4'(N))) ? mem[addr] : '0;
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand buffer and skewed streamer for the 4x4 systolic array (SYSTOLIC_FEEDER_DBUF_EN selects double buffering)
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic                  wr_sel_i,
  input  logic [3:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  array_rst_no,
  output logic [DATA_WIDTH-1:0] left_o_0,
  output logic [DATA_WIDTH-1:0] left_o_1,
  output logic [DATA_WIDTH-1:0] left_o_2,
  output logic [DATA_WIDTH-1:0] left_o_3,
  output logic [DATA_WIDTH-1:0] up_o_0,
  output logic [DATA_WIDTH-1:0] up_o_1,
  output logic [DATA_WIDTH-1:0] up_o_2,
  output logic [DATA_WIDTH-1:0] up_o_3
);

  state_t state, state_nxt;
  logic [2:0] step, step_nxt;
  logic       rd_en;
  logic [N*DATA_WIDTH-1:0] a_rows, b_cols;

  // state and step counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // sequencing: step counts within STREAM/DRAIN and restarts at every state change
  always_comb begin
    state_nxt = state;
    step_nxt  = step + 3'd1;
    unique case (state)
      IDLE: begin
        step_nxt = '0;
        if (start_i) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = STREAM;
        step_nxt  = '0;
      end
      STREAM: begin
        if (step == 3'(STREAM_LEN - 1)) begin
          state_nxt = DRAIN;
          step_nxt  = '0;
        end
      end
      DRAIN: begin
        if (step == 3'(DRAIN_LEN - 1)) begin
          state_nxt = DONE;
          step_nxt  = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase
  end

  // banks are read with the upcoming step so the registered outputs line up with the state
  assign rd_en = (state_nxt == STREAM);

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  logic active, active_nxt, shadow;
  logic [N*DATA_WIDTH-1:0] a_rows_0, a_rows_1, b_cols_0, b_cols_1;

  // swap takes effect at the end of CLEAR; a write landing on that edge goes to the new shadow
  assign active_nxt = (state == CLEAR) ? ~active : active;
  assign shadow     = ~active_nxt;

  // active-bank pointer
  always_ff @(posedge clk_i) begin
    if (!rst_ni) active <= 1'b0;
    else         active <= active_nxt;
  end

  feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .COL_READ(1'b0)) u_bank_a0 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_en_i(wr_en_i && !wr_sel_i && !shadow), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en && !active_nxt), .rd_step_i(step_nxt), .rd_data_o(a_rows_0)
  );
  feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .COL_READ(1'b0)) u_bank_a1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_en_i(wr_en_i && !wr_sel_i && shadow), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en && active_nxt), .rd_step_i(step_nxt), .rd_data_o(a_rows_1)
  );
  feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .COL_READ(1'b1)) u_bank_b0 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_en_i(wr_en_i && wr_sel_i && !shadow), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en && !active_nxt), .rd_step_i(step_nxt), .rd_data_o(b_cols_0)
  );
  feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .COL_READ(1'b1)) u_bank_b1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_en_i(wr_en_i && wr_sel_i && shadow), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en && active_nxt), .rd_step_i(step_nxt), .rd_data_o(b_cols_1)
  );

  // the idle bank reads as zero, so OR acts as the bank mux
  assign a_rows = a_rows_0 | a_rows_1;
  assign b_cols = b_cols_0 | b_cols_1;
`else
  logic wr_ok;

  // single bank: the operands must stay frozen while an operation runs
  assign wr_ok = wr_en_i && (state == IDLE);

  feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .COL_READ(1'b0)) u_bank_a (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_en_i(wr_ok && !wr_sel_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en), .rd_step_i(step_nxt), .rd_data_o(a_rows)
  );
  feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .COL_READ(1'b1)) u_bank_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_en_i(wr_ok && wr_sel_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en), .rd_step_i(step_nxt), .rd_data_o(b_cols)
  );
`endif

  // registered control and data outputs, all derived from the upcoming state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      array_rst_no <= 1'b0;
      left_o_0     <= '0;
      left_o_1     <= '0;
      left_o_2     <= '0;
      left_o_3     <= '0;
      up_o_0       <= '0;
      up_o_1       <= '0;
      up_o_2       <= '0;
      up_o_3       <= '0;
    end else begin
      busy_o       <= (state_nxt != IDLE);
      done_o       <= (state_nxt == DONE);
      array_rst_no <= (state_nxt != CLEAR);
      left_o_0     <= a_rows[0*DATA_WIDTH +: DATA_WIDTH];
      left_o_1     <= a_rows[1*DATA_WIDTH +: DATA_WIDTH];
      left_o_2     <= a_rows[2*DATA_WIDTH +: DATA_WIDTH];
      left_o_3     <= a_rows[3*DATA_WIDTH +: DATA_WIDTH];
      up_o_0       <= b_cols[0*DATA_WIDTH +: DATA_WIDTH];
      up_o_1       <= b_cols[1*DATA_WIDTH +: DATA_WIDTH];
      up_o_2       <= b_cols[2*DATA_WIDTH +: DATA_WIDTH];
      up_o_3       <= b_cols[3*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized self-checking bench for systolic_feeder against a matrix-level model
module tb_systolic_feeder;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, wr_sel, start;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done, arst_n;
  logic [DW-1:0] l0, l1, l2, l3, u0, u1, u2, u3;

  int ntests = 0;
  int nfail  = 0;

  // model: active and shadow copies of A and B, indexed row*4+col
  logic [DW-1:0] a_act [16];
  logic [DW-1:0] a_sh  [16];
  logic [DW-1:0] b_act [16];
  logic [DW-1:0] b_sh  [16];

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .start_i(start), .busy_o(busy), .done_o(done), .array_rst_no(arst_n),
    .left_o_0(l0), .left_o_1(l1), .left_o_2(l2), .left_o_3(l3),
    .up_o_0(u0), .up_o_1(u1), .up_o_2(u2), .up_o_3(u3)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 16; k++) begin
      a_act[k] = '0; a_sh[k] = '0; b_act[k] = '0; b_sh[k] = '0;
    end
  endtask

  task automatic swap_model();
    logic [DW-1:0] t;
    for (int k = 0; k < 16; k++) begin
      t = a_act[k]; a_act[k] = a_sh[k]; a_sh[k] = t;
      t = b_act[k]; b_act[k] = b_sh[k]; b_sh[k] = t;
    end
  endtask

  // an accepted write: double-buffered builds always fill the shadow copy
  task automatic model_write(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    if (sel) b_sh[addr] = data; else a_sh[addr] = data;
`else
    if (sel) b_act[addr] = data; else a_act[addr] = data;
`endif
  endtask

  function automatic logic [DW-1:0] left_exp(input int i, input int s);
    int k = s - i;
    return (k >= 0 && k <= 3) ? a_act[i*4 + k] : '0;
  endfunction

  function automatic logic [DW-1:0] up_exp(input int j, input int s);
    int k = s - j;
    return (k >= 0 && k <= 3) ? b_act[k*4 + j] : '0;
  endfunction

  // compare every output; s < 0 means all data outputs are expected to be 0
  task automatic check_all(input string tag, input logic eb, input logic ed, input logic ea, input int s);
    logic [DW-1:0] gl [4];
    logic [DW-1:0] gu [4];
    gl = '{l0, l1, l2, l3};
    gu = '{u0, u1, u2, u3};
    check($sformatf("%s busy", tag), {31'd0, busy}, {31'd0, eb});
    check($sformatf("%s done", tag), {31'd0, done}, {31'd0, ed});
    check($sformatf("%s arst_n", tag), {31'd0, arst_n}, {31'd0, ea});
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s left%0d", tag, i), gl[i], (s < 0) ? '0 : left_exp(i, s));
      check($sformatf("%s up%0d", tag, i), gu[i], (s < 0) ? '0 : up_exp(i, s));
    end
  endtask

  task automatic write_el(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_write(sel, addr, data);
  endtask

  // one full operation from an IDLE cycle; optional write in cycle wc (0 = with start)
  // and an extra start pulse in cycle sc
  task automatic run_op(input string name, input int wc, input logic wsel, input logic [3:0] waddr,
                        input logic [DW-1:0] wdata, input int sc);
    start = 1'b1;
    if (wc == 0) begin
      wr_en = 1'b1; wr_sel = wsel; wr_addr = waddr; wr_data = wdata;
    end
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    if (wc == 0) model_write(wsel, waddr, wdata);
    for (int c = 1; c <= 14; c++) begin
      check_all($sformatf("%s c%0d", name, c), c <= 13, c == 13, c != 1,
                (c >= 2 && c <= 8) ? c - 2 : -1);
      if (c == 14) break;
      if (c == wc) begin
        wr_en = 1'b1; wr_sel = wsel; wr_addr = waddr; wr_data = wdata;
      end
      if (c == sc) start = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0;
      start = 1'b0;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
      if (c == 1) swap_model();
      if (c == wc) model_write(wsel, waddr, wdata);
`endif
    end
  endtask

  // start, then reset in the cycle of STREAM step rs-2
  task automatic run_abort(input string name, input int rc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= rc; c++) begin
      check_all($sformatf("%s c%0d", name, c), 1'b1, 1'b0, c != 1,
                (c >= 2 && c <= 8) ? c - 2 : -1);
      if (c == rc) rst_n = 1'b0;
      @(posedge clk); #1;
    end
    clear_model();
    for (int r = 0; r < 3; r++) begin
      check_all($sformatf("%s rst%0d", name, r), 1'b0, 1'b0, 1'b0, -1);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all($sformatf("%s released", name), 1'b0, 1'b0, 1'b1, -1);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, -1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("idle", 1'b0, 1'b0, 1'b1, -1);

    // skew pattern A[i][k]=10i+k+1, B[k][j]=100k+j
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        write_el(1'b0, 4'(i*4 + k), DW'(10*i + k + 1));
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        write_el(1'b1, 4'(k*4 + j), DW'(100*k + j));
    run_op("skew", -1, 1'b0, 4'd0, '0, -1);

    // start pulse while busy is ignored; back-to-back start from cycle 14
    run_op("busy_start", -1, 1'b0, 4'd0, '0, 5);

    // write A[0][0]=99 during cycle 4, then run again
    run_op("busy_write", 4, 1'b0, 4'd0, DW'(99), -1);
    run_op("after_write", -1, 1'b0, 4'd0, '0, -1);

    // write together with start
    run_op("write_start", 0, 1'b1, 4'd5, DW'(32'hABCD), -1);

    // reset at STREAM s=3, then a fresh run over cleared storage
    run_abort("abort", 5);
    run_op("post_reset", -1, 1'b0, 4'd0, '0, -1);

    // randomized operand sets with a random write somewhere in the operation
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 16; k++) begin
        write_el(1'b0, 4'(k), DW'($urandom));
        write_el(1'b1, 4'(k), DW'($urandom));
      end
      run_op($sformatf("rand%0d", t), int'($urandom_range(0, 13)), 1'($urandom),
             4'($urandom), DW'($urandom), int'($urandom_range(1, 13)));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
